multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `rst_n`, input, 1 bit: reset that is synchronous and active-low, sampled on the rising edge of `clk`.
REQ-003 The block SHALL have the port `opcode`, input, 7 bits: instruction[6:0] from the datapath instruction register, valid from DECODE onward.
REQ-004 The block SHALL have the port `zero`, input, 1 bit: ALU zero flag, which selects the branch outcome.
REQ-005 The block SHALL have the port `memReady`, input, 1 bit: memory completes the current access in this cycle.
REQ-006 The block SHALL have the outputs `pcWrite`, `irWrite`, `memRead`, `memWrite`, `iOrD`, `regWrite`, `memToReg` and `pcSource`, 1 bit each:
- `iOrD`: 0 = PC address, 1 = ALUOut address.
- `pcSource`: 0 = ALU result, 1 = ALUOut.
REQ-007 The block SHALL have the output `aluSrcA`, 2 bits: 00 = PC, 01 = rs1, 10 = oldPC.
REQ-008 The block SHALL have the output `aluSrcB`, 2 bits: 00 = rs2, 01 = constant 4, 10 = immediate.
REQ-009 The block SHALL have the output `aluOp`, 2 bits: 00 = add, 01 = branch compare, 10 = funct decode.
REQ-010 The block SHALL have the output `state`, 3 bits: current FSM state, for debug.
REQ-011 The block SHALL have the output `illegalInstr`, 1 bit: a one-cycle pulse when DECODE sees an unsupported opcode.
REQ-012 The block SHALL have the output `instRetired`, 32 bits: count of completed instructions.

Function
REQ-013 States SHALL be encoded FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4; codes 5-7 SHALL go to FETCH on the next edge with all outputs 0.
REQ-014 Supported opcodes SHALL be:
- LOAD 0000011
- STORE 0100011
- BRANCH 1100011
- OPIMM 0010011
- OP 0110011
REQ-015 Unless stated otherwise for a state, every strobe and select output SHALL be 0.
REQ-016 FETCH outputs SHALL be: `memRead`=1, `iOrD`=0, `aluSrcA`=00, `aluSrcB`=01, `aluOp`=00.
REQ-017 In FETCH with `memReady`=1: `irWrite`=1, `pcWrite`=1, `pcSource`=0, and next state = DECODE.
REQ-018 In FETCH with `memReady`=0: the FSM SHALL stay in FETCH, with `irWrite`=`pcWrite`=0 and `memRead` held at 1.
REQ-019 DECODE outputs SHALL be `aluSrcA`=10, `aluSrcB`=10, `aluOp`=00 (branch target computed into ALUOut).
REQ-020 In DECODE, a supported opcode SHALL lead to EXECUTE.
REQ-021 In DECODE, any other opcode SHALL drive `illegalInstr`=1 for that cycle and next state = FETCH; nothing else is written and the count is unchanged.
REQ-022 EXECUTE for LOAD or STORE SHALL drive `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00, with next state = MEM.
REQ-023 EXECUTE for OPIMM SHALL drive `aluSrcA`=01, `aluSrcB`=10, `aluOp`=10, with next state = WRITEBACK.
REQ-024 EXECUTE for OP SHALL drive `aluSrcA`=01, `aluSrcB`=00, `aluOp`=10, with next state = WRITEBACK.
REQ-025 EXECUTE for BRANCH SHALL drive `aluSrcA`=01, `aluSrcB`=00, `aluOp`=01, `pcSource`=1, `pcWrite`=`zero`, with next state = FETCH.
REQ-026 MEM SHALL drive `iOrD`=1, plus `memRead`=1 for LOAD or `memWrite`=1 for STORE.
REQ-027 While `memReady`=0 in MEM, the FSM SHALL hold MEM with the strobe held high.
REQ-028 On `memReady`=1 in MEM, LOAD SHALL go to WRITEBACK and STORE SHALL go to FETCH.
REQ-029 WRITEBACK SHALL drive `regWrite`=1, with `memToReg`=1 for LOAD and 0 otherwise; next state = FETCH.
REQ-030 `memRead` and `memWrite` SHALL never both be 1 in the same cycle.
REQ-031 `instRetired` SHALL increment by 1 on the edge leaving any of these three: EXECUTE for BRANCH, MEM for a completed STORE, or WRITEBACK.
REQ-032 `instRetired` SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 Cycle counts with zero-wait memory SHALL be: BRANCH 3, STORE 4, OP/OPIMM 4, LOAD 5.
REQ-034 Each wait cycle with `memReady`=0 SHALL add exactly one cycle to the instruction.
REQ-035 `opcode` SHALL be sampled combinationally each cycle; the datapath guarantees it is stable from DECODE until the return to FETCH.

Reset
REQ-036 While `rst_n`=0 at a rising edge, the next state SHALL be FETCH and `instRetired` SHALL be 0.
REQ-037 In any cycle where `rst_n`=0, all outputs except `state` and `instRetired` SHALL be forced to 0.
REQ-038 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction; it is not counted and no write strobe is issued after the reset edge.
REQ-039 After `rst_n` rises, the first cycle SHALL be FETCH with `memRead`=1.

Verification
REQ-040 The bench SHALL cover: OP 0110011 with `memReady`=1 always -> states 0,1,2,4,0; `regWrite`=1 only in the WRITEBACK cycle; `instRetired` 0 -> 1.
REQ-041 The bench SHALL cover: LOAD with `memReady` low for 2 cycles in FETCH and 3 cycles in MEM -> 10 cycles total; `memRead` high throughout; `memToReg`=`regWrite`=1 in WRITEBACK.
REQ-042 The bench SHALL cover: BRANCH with `zero`=1, then with `zero`=0 -> `pcWrite`=1 and `pcSource`=1 in EXECUTE for the first, `pcWrite`=0 for the second; each instruction takes 3 cycles.
REQ-043 The bench SHALL cover: opcode 1111111 -> `illegalInstr` pulses for exactly 1 cycle in DECODE, the FSM returns to FETCH, and `instRetired` is unchanged.
REQ-044 The bench SHALL cover: `rst_n`=0 during a STORE MEM wait -> `memWrite`=0 in that cycle and `state`=0 next; `instRetired`=0.
REQ-045 The bench SHALL cover: preload the count to 0xFFFFFFFF by forcing it, then run one STORE -> `instRetired`=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle instruction-sequencing controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// FSM driving datapath strobes and selects, plus a retired-instruction counter.
module multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        memReady,
   output logic        pcWrite,
   output logic        irWrite,
   output logic        memRead,
   output logic        memWrite,
   output logic        iOrD,
   output logic        regWrite,
   output logic        memToReg,
   output logic        pcSource,
   output logic [1:0]  aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [1:0]  aluOp,
   output logic [2:0]  state,
   output logic        illegalInstr,
   output logic [31:0] instRetired
);

   // state     | meaning
   // FETCH     | read instruction at PC, PC+4 -> PC when memory completes
   // DECODE    | classify opcode, branch target oldPC+imm -> ALUOut
   // EXECUTE   | address calc, ALU op, or branch resolve
   // MEM       | data access at ALUOut, held until memReady
   // WRITEBACK | register file write from ALU or memory
   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4
   } stateT;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   stateT       curState;
   stateT       nextState;
   logic        retire;
   logic [31:0] retireCount;
   logic        isLoad;
   logic        isStore;
   logic        isBranch;
   logic        isOpImm;
   logic        isOp;

   assign isLoad   = (opcode == OP_LOAD);
   assign isStore  = (opcode == OP_STORE);
   assign isBranch = (opcode == OP_BRANCH);
   assign isOpImm  = (opcode == OP_OPIMM);
   assign isOp     = (opcode == OP_OP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         curState <= FETCH;
      end else begin
         curState <= nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retireCount <= '0;
      end else if (retire) begin
         retireCount <= retireCount + 32'd1;
      end
   end

   always_comb begin
      nextState    = FETCH;
      retire       = 1'b0;
      pcWrite      = 1'b0;
      irWrite      = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      iOrD         = 1'b0;
      regWrite     = 1'b0;
      memToReg     = 1'b0;
      pcSource     = 1'b0;
      aluSrcA      = 2'b00;
      aluSrcB      = 2'b00;
      aluOp        = 2'b00;
      illegalInstr = 1'b0;

      case (curState)
         FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            if (memReady) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               nextState = DECODE;
            end else begin
               nextState = FETCH;
            end
         end
         DECODE: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b10;
            if (isLoad || isStore || isBranch || isOpImm || isOp) begin
               nextState = EXECUTE;
            end else begin
               illegalInstr = 1'b1;
            end
         end
         EXECUTE: begin
            aluSrcA = 2'b01;
            if (isLoad || isStore) begin
               aluSrcB   = 2'b10;
               nextState = MEM;
            end else if (isOpImm) begin
               aluSrcB   = 2'b10;
               aluOp     = 2'b10;
               nextState = WRITEBACK;
            end else if (isOp) begin
               aluOp     = 2'b10;
               nextState = WRITEBACK;
            end else if (isBranch) begin
               aluOp    = 2'b01;
               pcSource = 1'b1;
               pcWrite  = zero;
               retire   = 1'b1;
            end
         end
         MEM: begin
            iOrD     = 1'b1;
            memRead  = isLoad;
            memWrite = isStore;
            if (!memReady && (isLoad || isStore)) begin
               nextState = MEM;
            end else if (isLoad) begin
               nextState = WRITEBACK;
            end else if (isStore) begin
               retire = 1'b1;
            end
         end
         WRITEBACK: begin
            regWrite = 1'b1;
            memToReg = isLoad;
            retire   = 1'b1;
         end
         default: nextState = FETCH;
      endcase

      // reset wins over everything the state would otherwise drive
      if (!rst_n) begin
         retire       = 1'b0;
         pcWrite      = 1'b0;
         irWrite      = 1'b0;
         memRead      = 1'b0;
         memWrite     = 1'b0;
         iOrD         = 1'b0;
         regWrite     = 1'b0;
         memToReg     = 1'b0;
         pcSource     = 1'b0;
         aluSrcA      = 2'b00;
         aluSrcB      = 2'b00;
         aluOp        = 2'b00;
         illegalInstr = 1'b0;
      end
   end

   assign state       = curState;
   assign instRetired = retireCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams compared against a per-instruction stage-sequence model.
module tb_multicycle_control;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        zero;
   logic        memReady;
   logic        pcWrite, irWrite, memRead, memWrite, iOrD, regWrite, memToReg, pcSource;
   logic [1:0]  aluSrcA, aluSrcB, aluOp;
   logic [2:0]  state;
   logic        illegalInstr;
   logic [31:0] instRetired;

   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] expCount = '0;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
      .iOrD(iOrD), .regWrite(regWrite), .memToReg(memToReg), .pcSource(pcSource),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .state(state),
      .illegalInstr(illegalInstr), .instRetired(instRetired)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] packOut();
      return {pcWrite, irWrite, memRead, memWrite, iOrD, regWrite, memToReg, pcSource,
              aluSrcA, aluSrcB, aluOp, illegalInstr};
   endfunction

   // Runs one whole instruction from FETCH. Stage list: fw+1 fetch cycles,
   // decode, then execute / mw+1 memory cycles / writeback as the class needs.
   task automatic runInstr(input logic [6:0] op, input logic z, input int fw, input int mw,
                           input string tag);
      int   seq[$];
      int   fCnt = 0;
      int   mCnt = 0;
      logic ld  = (op == OP_LOAD);
      logic st  = (op == OP_STORE);
      logic br  = (op == OP_BRANCH);
      logic oi  = (op == OP_OPIMM);
      logic alu = (op == OP_OP);
      logic ill = !(ld || st || br || oi || alu);
      logic rdy;
      logic [14:0] expOut;
      logic [1:0]  eA, eB, eOp;
      for (int i = 0; i <= fw; i++) seq.push_back(0);
      seq.push_back(1);
      if (!ill) begin
         seq.push_back(2);
         if (ld || st) for (int i = 0; i <= mw; i++) seq.push_back(3);
         if (ld || oi || alu) seq.push_back(4);
      end
      for (int k = 0; k < seq.size(); k++) begin
         int s = seq[k];
         @(negedge clk);
         opcode = op;
         zero   = z;
         if (s == 0) begin
            rdy = (fCnt == fw);
            fCnt++;
         end else if (s == 3) begin
            rdy = (mCnt == mw);
            mCnt++;
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         memReady = rdy;
         #1;
         eA  = (s == 1) ? 2'b10 : (s == 2) ? 2'b01 : 2'b00;
         eB  = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : (s == 2 && (ld || st || oi)) ? 2'b10 : 2'b00;
         eOp = (s != 2) ? 2'b00 : br ? 2'b01 : (oi || alu) ? 2'b10 : 2'b00;
         expOut = {(s == 0 && rdy) || (s == 2 && br && z),
                   (s == 0 && rdy),
                   (s == 0) || (s == 3 && ld),
                   (s == 3 && st),
                   (s == 3),
                   (s == 4),
                   (s == 4 && ld),
                   (s == 2 && br),
                   eA, eB, eOp,
                   (s == 1 && ill)};
         vectors++;
         if (packOut() !== expOut) begin
            errors++;
            $display("FAIL %s outputs cycle %0d: got %h expected %h", tag, k, packOut(), expOut);
         end
         vectors++;
         if (state !== 3'(s)) begin
            errors++;
            $display("FAIL %s state cycle %0d: got %0d expected %0d", tag, k, state, s);
         end
         if (k == 0) begin
            vectors++;
            if (instRetired !== expCount) begin
               errors++;
               $display("FAIL %s count at start: got %h expected %h", tag, instRetired, expCount);
            end
         end
      end
      if (!ill) expCount = expCount + 32'd1;
   endtask

   task automatic checkIdle(input string tag);
      @(negedge clk);
      memReady = 1'b0;
      #1;
      vectors++;
      if (state !== 3'd0 || instRetired !== expCount) begin
         errors++;
         $display("FAIL %s idle: state %0d count %h, expected state 0 count %h",
                  tag, state, instRetired, expCount);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; memReady = 1'b1; opcode = OP_OP; zero = 1'b1;
      repeat (2) begin
         @(negedge clk);
         #1;
         vectors++;
         if (packOut() !== 15'h0 || state !== 3'd0 || instRetired !== 32'd0) begin
            errors++;
            $display("FAIL reset hold: outs %h state %0d count %h, expected 0/0/0",
                     packOut(), state, instRetired);
         end
      end
      rst_n = 1'b1;
      memReady = 1'b0;
      #1;
      vectors++;
      if (memRead !== 1'b1 || state !== 3'd0) begin
         errors++;
         $display("FAIL reset release: memRead %b state %0d, expected 1 and 0", memRead, state);
      end
      expCount = '0;
   endtask

   task automatic test_op();
      runInstr(OP_OP, 1'b0, 0, 0, "op");
      checkIdle("op_retired");
   endtask

   task automatic test_load_waits();
      runInstr(OP_LOAD, 1'b0, 2, 3, "load_waits");
      checkIdle("load_retired");
   endtask

   task automatic test_branch();
      runInstr(OP_BRANCH, 1'b1, 0, 0, "branch_taken");
      runInstr(OP_BRANCH, 1'b0, 0, 0, "branch_not_taken");
      checkIdle("branch_retired");
   endtask

   task automatic test_illegal();
      runInstr(7'b1111111, 1'b0, 0, 0, "illegal");
      checkIdle("illegal_uncounted");
   endtask

   task automatic test_random();
      logic [6:0] ops[5] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_OPIMM, OP_OP};
      logic [6:0] op;
      for (int n = 0; n < 40; n++) begin
         int pick = $urandom_range(0, 5);
         if (pick < 5) begin
            op = ops[pick];
         end else begin
            do op = 7'($urandom);
            while (op == OP_LOAD || op == OP_STORE || op == OP_BRANCH || op == OP_OPIMM || op == OP_OP);
         end
         runInstr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), "random");
      end
      checkIdle("random_end");
   endtask

   task automatic test_reset_mid_store();
      logic rdySeq[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      int   stSeq[5]  = '{0, 1, 2, 3, 3};
      opcode = OP_STORE;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         memReady = rdySeq[k];
         #1;
         vectors++;
         if (state !== 3'(stSeq[k])) begin
            errors++;
            $display("FAIL store_abort state cycle %0d: got %0d expected %0d", k, state, stSeq[k]);
         end
      end
      vectors++;
      if (memWrite !== 1'b1) begin
         errors++;
         $display("FAIL store_abort wait strobe: memWrite %b expected 1", memWrite);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (memWrite !== 1'b0 || packOut() !== 15'h0) begin
         errors++;
         $display("FAIL store_abort reset cycle: memWrite %b outs %h expected 0 and 0", memWrite, packOut());
      end
      @(negedge clk);
      #1;
      vectors++;
      if (state !== 3'd0 || instRetired !== 32'd0) begin
         errors++;
         $display("FAIL store_abort after reset: state %0d count %h expected 0 and 0", state, instRetired);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (memRead !== 1'b1 || state !== 3'd0) begin
         errors++;
         $display("FAIL store_abort restart: memRead %b state %0d expected 1 and 0", memRead, state);
      end
      expCount = '0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      memReady = 1'b0;
      force dut.retireCount = 32'hFFFF_FFFF;
      release dut.retireCount;
      expCount = 32'hFFFF_FFFF;
      runInstr(OP_STORE, 1'b0, 0, 0, "wrap_store");
      checkIdle("wrap");
      vectors++;
      if (instRetired !== 32'd0) begin
         errors++;
         $display("FAIL wrap value: got %h expected 00000000", instRetired);
      end
   endtask

   initial begin
      rst_n = 1'b0; memReady = 1'b0; opcode = '0; zero = 1'b0;
      test_reset();
      test_op();
      test_load_waits();
      test_branch();
      test_illegal();
      test_random();
      test_reset_mid_store();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time budget");
      $fatal(1, "timeout");
   end

endmodule
